// File: rtl/ysyx_22040386_hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, control bundle, fixed bundles.
package ysyx_22040386_hazard_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_TIMEOUT  = 2'd2;

   typedef struct packed {
      logic pc_we;
      logic if_id_we;
      logic if_id_flush;
      logic id_ex_we;
      logic id_ex_flush;
      logic ex_mem_we;
      logic mem_wb_flush;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN = '{
      pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0, id_ex_we: 1'b1,
      id_ex_flush: 1'b0, ex_mem_we: 1'b1, mem_wb_flush: 1'b0
   };

   // Everything holds; only MEM/WB takes a bubble so WB does not retire the stalled access twice.
   localparam ctrl_t CTRL_FREEZE = '{
      pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_we: 1'b0,
      id_ex_flush: 1'b0, ex_mem_we: 1'b0, mem_wb_flush: 1'b1
   };

   localparam ctrl_t CTRL_RESET = '{
      pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1, id_ex_we: 1'b0,
      id_ex_flush: 1'b1, ex_mem_we: 1'b0, mem_wb_flush: 1'b1
   };

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ysyx_22040386_hazard_perf.sv
// Saturating event counters for the hazard controller (built only with HAZARD_PERF_CNT_EN).
module ysyx_22040386_hazard_perf
   import ysyx_22040386_hazard_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        loaduse_inc,
   input  logic        memwait_inc,
   input  logic        redirect_inc,
   output logic [31:0] loaduse_cnt,
   output logic [31:0] memwait_cnt,
   output logic [31:0] redirect_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loaduse_cnt  <= '0;
         memwait_cnt  <= '0;
         redirect_cnt <= '0;
      end else begin
         if (loaduse_inc)  loaduse_cnt  <= sat_inc32(loaduse_cnt);
         if (memwait_inc)  memwait_cnt  <= sat_inc32(memwait_cnt);
         if (redirect_inc) redirect_cnt <= sat_inc32(redirect_cnt);
      end
   end

endmodule

// File: rtl/ysyx_22040386_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubble, memory-wait freeze, redirect flush.
// Optional build macro HAZARD_PERF_CNT_EN adds three saturating performance counters.
module ysyx_22040386_hazard_ctrl
   import ysyx_22040386_hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_IF_valid,
   input  logic [4:0] i_IF_ID_reg_rd_addr1,
   input  logic [4:0] i_IF_ID_reg_rd_addr2,
   input  logic       i_IF_ID_rs1_used,
   input  logic       i_IF_ID_rs2_used,
   input  logic       i_ID_EX_MemRead,
   input  logic [4:0] i_ID_EX_reg_wr_addr,
   input  logic       i_EX_redirect,
   input  logic       i_MEM_req,
   input  logic       i_MEM_ack,
   output logic       o_pc_we,
   output logic       o_IF_ID_we,
   output logic       o_IF_ID_flush,
   output logic       o_ID_EX_we,
   output logic       o_ID_EX_flush,
   output logic       o_EX_MEM_we,
   output logic       o_MEM_WB_flush,
   output logic       o_mem_timeout,
   output logic [1:0] o_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] o_perf_loaduse_cnt,
   output logic [31:0] o_perf_memwait_cnt,
   output logic [31:0] o_perf_redirect_cnt
`endif
);

   localparam bit             TIMEOUT_EN  = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             timeout_q, timeout_nxt;

   logic  mem_stall, load_use, rs1_hit, rs2_hit, freeze;
   ctrl_t ctrl;

   assign mem_stall = i_MEM_req && !i_MEM_ack;
   assign rs1_hit   = i_IF_ID_rs1_used && (i_IF_ID_reg_rd_addr1 == i_ID_EX_reg_wr_addr);
   assign rs2_hit   = i_IF_ID_rs2_used && (i_IF_ID_reg_rd_addr2 == i_ID_EX_reg_wr_addr);
   assign load_use  = i_ID_EX_MemRead && (i_ID_EX_reg_wr_addr != 5'd0) && (rs1_hit || rs2_hit);

   // After a timeout the pipe stays held on a dropped request too; only an ack releases it.
   assign freeze = mem_stall || ((state == ST_TIMEOUT) && !i_MEM_ack);

   // NOTE: every path assigns ctrl from a full default first, so no latch can be inferred.
   always_comb begin
      ctrl = CTRL_RUN;
      if (!i_rst_n) begin
         ctrl = CTRL_RESET;
      end else if (freeze) begin
         ctrl = CTRL_FREEZE;
      end else if (i_EX_redirect) begin
         ctrl.if_id_flush = 1'b1;
         ctrl.id_ex_flush = 1'b1;
      end else if (load_use) begin
         ctrl.pc_we       = 1'b0;
         ctrl.if_id_we    = 1'b0;
         ctrl.id_ex_flush = 1'b1;
      end else if (!i_IF_valid) begin
         ctrl.pc_we       = 1'b0;
         ctrl.if_id_flush = 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      timeout_nxt = timeout_q;
      case (state)
         ST_RUN: begin
            if (mem_stall) begin
               state_nxt = ST_MEM_WAIT;
               cnt_nxt   = CNT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_stall) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else if (TIMEOUT_EN && (cnt == TIMEOUT_CNT)) begin
               state_nxt   = ST_TIMEOUT;
               timeout_nxt = 1'b1;
            end else if (cnt != '1) begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_TIMEOUT: begin
            if (i_MEM_ack) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_RUN;
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   assign o_pc_we        = ctrl.pc_we;
   assign o_IF_ID_we     = ctrl.if_id_we;
   assign o_IF_ID_flush  = ctrl.if_id_flush;
   assign o_ID_EX_we     = ctrl.id_ex_we;
   assign o_ID_EX_flush  = ctrl.id_ex_flush;
   assign o_EX_MEM_we    = ctrl.ex_mem_we;
   assign o_MEM_WB_flush = ctrl.mem_wb_flush;
   assign o_mem_timeout  = timeout_q;
   assign o_state        = state;

`ifdef HAZARD_PERF_CNT_EN
   logic perf_loaduse, perf_memwait, perf_redirect;

   assign perf_loaduse  = (state == ST_RUN) && !freeze && !i_EX_redirect && load_use;
   assign perf_memwait  = (state == ST_MEM_WAIT) || (state == ST_TIMEOUT);
   assign perf_redirect = !freeze && i_EX_redirect;

   ysyx_22040386_hazard_perf u_perf (
      .clk          (i_clk),
      .rst_n        (i_rst_n),
      .loaduse_inc  (perf_loaduse),
      .memwait_inc  (perf_memwait),
      .redirect_inc (perf_redirect),
      .loaduse_cnt  (o_perf_loaduse_cnt),
      .memwait_cnt  (o_perf_memwait_cnt),
      .redirect_cnt (o_perf_redirect_cnt)
   );
`endif

endmodule

// File: doc/ysyx_22040386_hazard_ctrl.md
Name: ysyx_22040386_hazard_ctrl

Overview:
Pipeline stall/flush controller for the 5-stage core. It is the counterpart of the forwarding network: it handles the hazards that forwarding cannot resolve.
- load-use: insert bubble
- data-memory handshake wait: freeze pipeline
- EX branch/jump redirect: flush younger stages
- fetch not valid: bubble into ID
It drives the write-enable and flush controls of the PC and all four pipeline registers.

Parameters:
MEM_TIMEOUT, 255, MEM_WAIT cycles before the sticky timeout flag is set; 0 disables the timeout.
CNT_W, 8, width of the MEM_WAIT cycle counter; must satisfy MEM_TIMEOUT < 2^CNT_W.

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  asynchronous active-low reset
i_IF_valid  in  1  fetched instruction valid this cycle
i_IF_ID_reg_rd_addr1  in  5  rs1 of instruction in ID
i_IF_ID_reg_rd_addr2  in  5  rs2 of instruction in ID
i_IF_ID_rs1_used  in  1  ID instruction reads rs1
i_IF_ID_rs2_used  in  1  ID instruction reads rs2
i_ID_EX_MemRead  in  1  instruction in EX is a load
i_ID_EX_reg_wr_addr  in  5  rd of instruction in EX
i_EX_redirect  in  1  taken branch/jump resolved in EX
i_MEM_req  in  1  MEM stage issuing data-memory access
i_MEM_ack  in  1  data memory completes access
o_pc_we  out  1  PC update enable
o_IF_ID_we  out  1  IF/ID register enable
o_IF_ID_flush  out  1  load NOP into IF/ID
o_ID_EX_we  out  1  ID/EX register enable
o_ID_EX_flush  out  1  load NOP into ID/EX
o_EX_MEM_we  out  1  EX/MEM register enable
o_MEM_WB_flush  out  1  load NOP into MEM/WB
o_mem_timeout  out  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT
o_state  out  2  FSM state (debug)

Behaviour:
- Clocking and reset: one clock i_clk; reset i_rst_n is asynchronous and active-low.
- States (2-bit): RUN=0, MEM_WAIT=1, TIMEOUT=2. Encoding 3 is unreachable and recovers to RUN.
- Reset (async, i_rst_n=0):
  - state=RUN, wait counter=0, o_mem_timeout=0.
  - While in reset, all *_we=0 and all *_flush=1, forced combinationally.
- Hazard conditions:
  - mem_stall = i_MEM_req && !i_MEM_ack.
  - load_use = i_ID_EX_MemRead && i_ID_EX_reg_wr_addr!=0 && ((rs1_used && rd_addr1==wr_addr) || (rs2_used && rd_addr2==wr_addr)).
- Priority, applied each cycle: mem_stall > i_EX_redirect > load_use > !i_IF_valid > normal.
- RUN, outputs combinational, same cycle:
  - mem_stall: all we=0, o_MEM_WB_flush=1; next state MEM_WAIT, counter cleared to 1.
  - redirect: pc_we=1, IF_ID_we=1, IF_ID_flush=1, ID_EX_flush=1, EX_MEM_we=1. A concurrent load_use is discarded.
  - load_use: pc_we=0, IF_ID_we=0, ID_EX_flush=1, EX_MEM_we=1. Exactly one bubble; the next cycle resolves via MEM/WB forwarding.
  - !i_IF_valid: pc_we=0, IF_ID_flush=1, downstream stages advance.
  - normal: all we=1, all flush=0.
- MEM_WAIT:
  - Same frozen outputs as mem_stall; the counter increments and saturates at 2^CNT_W-1.
  - i_MEM_ack=1: this cycle outputs normal RUN control (the access completes and the pipeline advances); next state RUN. Redirect and load_use are evaluated in this same cycle with the priority above.
  - i_MEM_req drops without ack: protocol violation; return to RUN, no flag set.
  - If MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT with no ack: set o_mem_timeout, go to TIMEOUT.
- TIMEOUT: pipeline stays frozen until ack, then RUN. o_mem_timeout stays 1 until reset.
- No registered output latency: every control output is a function of current state and inputs. Only state, counter and flag are flops.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds three 32-bit saturating outputs, each reset to 0:
  - o_perf_loaduse_cnt: RUN cycles with load_use taken.
  - o_perf_memwait_cnt: cycles in MEM_WAIT or TIMEOUT.
  - o_perf_redirect_cnt: redirect flushes taken.
- Undefined: these ports and their logic are absent. Control behaviour is identical in both builds.

Decomposition:
- Package ysyx_22040386_hazard_pkg: state encoding localparams (RUN/MEM_WAIT/TIMEOUT), a control-bundle struct (pc_we, stage we/flush bits), and the CTRL_RUN and CTRL_FREEZE constant bundles.
- Sub-module ysyx_22040386_hazard_perf: the three saturating counters, instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: lw x5 in EX (MemRead=1, wr=5), ID rs1=5 used → one cycle of pc_we=0, IF_ID_we=0, ID_EX_flush=1; next cycle all we=1.
- Load-use to x0: MemRead=1, wr=0, rs1=0 → no stall; rs2 match with rs2_used=0 → no stall.
- Memory wait: req=1, ack=0 for 3 cycles, then ack → 3 frozen cycles (MEM_WB_flush=1), o_state=1, then RUN with all we=1 on the ack cycle.
- Redirect and load-use in the same cycle → IF_ID_flush=1, ID_EX_flush=1, pc_we=1, no load-use bubble; redirect during mem_stall is held until ack.
- Timeout with MEM_TIMEOUT=4: req held, no ack → o_mem_timeout=1 after the 4th wait cycle, o_state=2; ack → RUN, flag stays 1.
- Async reset asserted mid-MEM_WAIT → state=RUN, flag=0, counter=0 immediately with no clock edge; outputs forced we=0, flush=1 until release.
